// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_pkg
// Purpose  : Shared constants for the up/down modulo counter family:
//            counting direction and boundary behaviour (wrap or saturate).
// Revision : 1.0  initial release
// ============================================================================
package counter_pkg;

  // Counting direction as carried on the 'up' input
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // Behaviour when a step would cross 0 or MAX
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_step.sv
`default_nettype none
// ============================================================================
// Module   : counter_step
// Purpose  : Combinational next-count and boundary-event calculator for a
//            modulo counter with range 0..MAX. The modulus is taken from
//            MAX explicitly, so non-power-of-two ranges wrap correctly.
// Revision : 1.0  initial release
// ============================================================================
module counter_step
  import counter_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter int unsigned MAX   = 2**WIDTH-1
) (
  input  logic [WIDTH-1:0] out,
  input  logic             up,
  input  logic             mode,
  output logic [WIDTH-1:0] next_val,
  output logic             boundary
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic at_max;
  logic at_zero;

  assign at_max  = (out == MAX_V);
  assign at_zero = (out == '0);

  // One step in the requested direction; at the edge of the range either
  // wrap to the opposite end or hold, and flag the boundary event.
  always_comb begin
    next_val = out;
    boundary = 1'b0;
    if (up == DIR_UP) begin
      if (at_max) begin
        boundary = 1'b1;
        next_val = (mode == MODE_SAT) ? MAX_V : '0;
      end else begin
        next_val = out + WIDTH'(1);
      end
    end else begin
      if (at_zero) begin
        boundary = 1'b1;
        next_val = (mode == MODE_SAT) ? '0 : MAX_V;
      end else begin
        next_val = out - WIDTH'(1);
      end
    end
  end

endmodule : counter_step
`default_nettype wire

// File: rtl/counter_updown_mod.sv
`default_nettype none
// ============================================================================
// Module   : counter_updown_mod
// Purpose  : Parametrised up/down modulo counter with parallel load, a
//            registered terminal-count pulse and an output-valid flag.
//            Priority each cycle: reset > load > enable.
// Options  : COUNTER_SAT_EN - adds the 'sat' input selecting saturation at
//            the range boundaries; without it the counter always wraps.
// Revision : 1.0  initial release
// ============================================================================
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int unsigned MAX       = 2**WIDTH-1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             out_valid
);

  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);

  logic             mode;
  logic [WIDTH-1:0] step_next;
  logic             step_boundary;
  logic [WIDTH-1:0] load_clamped;

`ifdef COUNTER_SAT_EN
  assign mode = sat ? MODE_SAT : MODE_WRAP;
`else
  assign mode = MODE_WRAP;
`endif

  // Out-of-range load values are clamped to the top of the count range
  assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

  counter_step #(
    .WIDTH (WIDTH),
    .MAX   (MAX)
  ) u_step (
    .out      (out),
    .up       (up),
    .mode     (mode),
    .next_val (step_next),
    .boundary (step_boundary)
  );

  // Count, tc and valid registers with reset > load > enable priority
  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= RESET_V;
      tc        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b1;
      if (load) begin
        out <= load_clamped;
        tc  <= 1'b0;
      end else if (enable) begin
        out <= step_next;
        tc  <= step_boundary;
      end else begin
        tc  <= 1'b0;
      end
    end
  end

endmodule : counter_updown_mod
`default_nettype wire

// File: tb/tb_counter_updown_mod.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_updown_mod
// Purpose  : Self-checking bench for counter_updown_mod. Two instances run
//            side by side on shared stimulus: an 8-bit full-range counter
//            (MAX=255) and a 4-bit decade counter (MAX=9). Each is checked
//            every cycle against an integer reference model, plus directed
//            expected values for the key scenarios.
// Options  : COUNTER_SAT_EN - also exercises the 'sat' input.
// Revision : 1.0  initial release
// ============================================================================
module tb_counter_updown_mod;

  localparam int A_MAX = 255;
  localparam int B_MAX = 9;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic       sat = 1'b0;

  logic [7:0] a_out;
  logic       a_tc, a_valid;
  logic [3:0] b_out;
  logic       b_tc, b_valid;

  int passed = 0;
  int total  = 0;

  // Reference model state
  int ma_cnt = 0, mb_cnt = 0;
  bit ma_tc = 0, mb_tc = 0, ma_v = 0, mb_v = 0;

  always #5 clk = ~clk;

  counter_updown_mod #(.WIDTH(8), .MAX(A_MAX), .RESET_VAL(0)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_val(load_val),
`ifdef COUNTER_SAT_EN
    .sat(sat),
`endif
    .out(a_out), .tc(a_tc), .out_valid(a_valid)
  );

  counter_updown_mod #(.WIDTH(4), .MAX(B_MAX), .RESET_VAL(0)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_val(load_val[3:0]),
`ifdef COUNTER_SAT_EN
    .sat(sat),
`endif
    .out(b_out), .tc(b_tc), .out_valid(b_valid)
  );

  function automatic bit sat_active();
`ifdef COUNTER_SAT_EN
    return sat;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: plain integer arithmetic over the range 0..maxv
  task automatic model_step(input int maxv, input int rstv, input int lv,
                            inout int cnt, inout bit t, inout bit v);
    int n;
    if (reset) begin
      cnt = rstv; t = 0; v = 0;
    end else begin
      v = 1;
      if (load) begin
        cnt = (lv > maxv) ? maxv : lv;
        t = 0;
      end else if (enable) begin
        n = up ? cnt + 1 : cnt - 1;
        t = 0;
        if (n > maxv) begin
          t = 1; n = sat_active() ? maxv : 0;
        end else if (n < 0) begin
          t = 1; n = sat_active() ? 0 : maxv;
        end
        cnt = n;
      end else begin
        t = 0;
      end
    end
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_all();
    cmp("a_out",   32'(a_out),   32'(ma_cnt));
    cmp("a_tc",    32'(a_tc),    32'(ma_tc));
    cmp("a_valid", 32'(a_valid), 32'(ma_v));
    cmp("b_out",   32'(b_out),   32'(mb_cnt));
    cmp("b_tc",    32'(b_tc),    32'(mb_tc));
    cmp("b_valid", 32'(b_valid), 32'(mb_v));
  endtask

  // Advance one clock: update the model from the inputs the DUT will
  // sample, then check the registered outputs just after the edge.
  task automatic tick();
    model_step(A_MAX, 0, int'(load_val),      ma_cnt, ma_tc, ma_v);
    model_step(B_MAX, 0, int'(load_val[3:0]), mb_cnt, mb_tc, mb_v);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int a_tc_seen;

    // Reset state
    reset = 1; load = 1; enable = 1; load_val = 8'd7;
    tick(); tick();
    cmp("rst_a_out", 32'(a_out), 0);
    cmp("rst_b_valid", 32'(b_valid), 0);

    // Full-range count up: A wraps 255 -> 0 exactly once in 258 steps
    reset = 0; load = 0; enable = 1; up = 1;
    a_tc_seen = 0;
    for (int i = 0; i < 258; i++) begin
      tick();
      if (a_tc) a_tc_seen++;
    end
    cmp("a_wrap_tc_count", 32'(a_tc_seen), 1);
    cmp("a_after_258", 32'(a_out), 2);

    // Decade count down from 0: 9,8,...,0,9
    load = 1; load_val = 8'd0; tick();
    load = 0; up = 0;
    tick();
    cmp("b_down_wrap_out", 32'(b_out), 9);
    cmp("b_down_wrap_tc", 32'(b_tc), 1);
    for (int i = 0; i < 10; i++) tick();
    cmp("b_down_second_wrap", 32'(b_out), 9);
    cmp("b_down_second_tc", 32'(b_tc), 1);
    enable = 0; tick();
    cmp("b_hold_tc_low", 32'(b_tc), 0);

    // Out-of-range load clamps to MAX; enable is ignored during load
    load = 1; enable = 1; load_val = 8'd12; tick();
    cmp("b_load_clamp", 32'(b_out), 9);
    cmp("b_load_tc", 32'(b_tc), 0);
    cmp("a_load_12", 32'(a_out), 12);
    load_val = 8'd200; tick();

    // Direction toggled every cycle from 3: 4,3,4,3 and no tc
    load_val = 8'd3; tick();
    load = 0; enable = 1;
    for (int i = 0; i < 8; i++) begin
      up = (i % 2 == 0);
      tick();
      cmp("toggle_b_out", 32'(b_out), (i % 2 == 0) ? 4 : 3);
      cmp("toggle_b_tc", 32'(b_tc), 0);
    end

    // Reset while counting, with load and enable also high
    load = 1; load_val = 8'd5; tick();
    load = 0; up = 1; tick();
    reset = 1; load = 1; enable = 1; load_val = 8'd8; tick();
    cmp("mid_rst_out", 32'(b_out), 0);
    cmp("mid_rst_valid", 32'(b_valid), 0);
    reset = 0; load = 0; tick();
    cmp("after_rst_valid", 32'(a_valid), 1);
    cmp("after_rst_count", 32'(b_out), 1);

`ifdef COUNTER_SAT_EN
    // Saturation at MAX: 9,9,9,9 with tc 0,1,1,1
    load = 1; load_val = 8'd8; enable = 0; tick();
    load = 0; enable = 1; up = 1; sat = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      cmp("sat_up_out", 32'(b_out), 9);
      cmp("sat_up_tc", 32'(b_tc), (i == 0) ? 0 : 1);
    end
    // Saturation at zero while counting down
    load = 1; load_val = 8'd1; tick();
    load = 0; up = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("sat_dn_out", 32'(b_out), 0);
      cmp("sat_dn_tc", 32'(b_tc), (i == 0) ? 0 : 1);
    end
    sat = 0;
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 500; i++) begin
      reset    = ($urandom_range(0, 31) == 0);
      load     = ($urandom_range(0, 7) == 0);
      enable   = ($urandom_range(0, 3) != 0);
      up       = ($urandom_range(0, 2) != 0);
      load_val = 8'($urandom);
      sat      = ($urandom_range(0, 1) == 1);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_counter_updown_mod
`default_nettype wire
